// File: rtl/sram_bank.sv
// ---------------------------------------------------------------------------
// sram_bank
// Memory-side responder for the dot-product SRAM controller. Holds Nums_SRAM
// independent single-clock RAMs of Ram_Depth words x Data_Width bits. Each RAM
// decodes its own slice of the packed control/address/data buses, supports a
// multi-cycle hardware clear, and returns registered read data one cycle after
// the read is accepted, together with a one-cycle valid strobe.
//
// Ports
//   clk            : sole clock, rising edge
//   Mem_reset      : synchronous active-high reset (array contents kept)
//   Mem_Clear      : per-RAM clear request
//   En_Chip_Select : per-RAM enable for reads/writes
//   En_Write       : per-RAM write strobe
//   En_Read        : per-RAM read strobe
//   Addr_Read      : packed read addresses, RAM i = [Ram_Depth*i +: Ram_Depth]
//   Addr_Write     : packed write addresses, same packing
//   Data_Write     : packed write data, RAM i = [Data_Width*i +: Data_Width]
//   Data_Read      : packed registered read data, same packing
//   Read_Valid     : per-RAM one-cycle pulse when Data_Read slice was updated
//   Clear_Busy     : per-RAM flag, high while that RAM runs a clear
// ---------------------------------------------------------------------------
module sram_bank #(
   parameter int Addr_Width = 4,
   parameter int Ram_Depth  = 1 << Addr_Width,
   parameter int Nums_SRAM  = 3,
   parameter int Data_Width = 8
) (
   input  logic                            clk,
   input  logic                            Mem_reset,
   input  logic [Nums_SRAM-1:0]            Mem_Clear,
   input  logic [Nums_SRAM-1:0]            En_Chip_Select,
   input  logic [Nums_SRAM-1:0]            En_Write,
   input  logic [Nums_SRAM-1:0]            En_Read,
   input  logic [Nums_SRAM*Ram_Depth-1:0]  Addr_Read,
   input  logic [Nums_SRAM*Ram_Depth-1:0]  Addr_Write,
   input  logic [Nums_SRAM*Data_Width-1:0] Data_Write,
   output logic [Nums_SRAM*Data_Width-1:0] Data_Read,
   output logic [Nums_SRAM-1:0]            Read_Valid,
   output logic [Nums_SRAM-1:0]            Clear_Busy
);

   typedef enum logic {
      Idle,
      Clearing
   } state_e;

   localparam logic [Addr_Width-1:0] LastAddr = Addr_Width'(Ram_Depth - 1);

   genvar g;
   generate
      for (g = 0; g < Nums_SRAM; g++) begin : gRam
         state_e                  state_q, state_d;
         logic [Addr_Width-1:0]   clearCnt_q, clearCnt_d;
         logic [Data_Width-1:0]   rdData_q, rdData_d;
         logic                    rdValid_q, rdValid_d;
         logic [Data_Width-1:0]   mem [Ram_Depth];
         logic [Addr_Width-1:0]   rdAddr, wrAddr;
         logic                    memWe;
         logic [Addr_Width-1:0]   memAddr;
         logic [Data_Width-1:0]   memWdata;
         logic [Ram_Depth-Addr_Width-1:0] unusedRdHi, unusedWrHi;

         // Only the low Addr_Width bits of each address field select a word;
         // the remaining bits of the field are deliberately left undecoded.
         assign rdAddr     = Addr_Read[Ram_Depth*g +: Addr_Width];
         assign wrAddr     = Addr_Write[Ram_Depth*g +: Addr_Width];
         assign unusedRdHi = Addr_Read[Ram_Depth*g+Addr_Width +: Ram_Depth-Addr_Width];
         assign unusedWrHi = Addr_Write[Ram_Depth*g+Addr_Width +: Ram_Depth-Addr_Width];

         // Next-state and array-port decode. In Idle a clear request wins over
         // any read/write on the same edge. In Clearing the single write port
         // is taken over by the sequencer, which zeroes one word per cycle and
         // ignores every command. The read samples the array before this
         // edge's write lands, so a same-address read returns the old word.
         // A reset edge performs no array write, so an aborted clear leaves
         // the not-yet-zeroed words untouched.
         always_comb begin
            state_d    = state_q;
            clearCnt_d = clearCnt_q;
            rdData_d   = rdData_q;
            rdValid_d  = 1'b0;
            memWe      = 1'b0;
            memAddr    = wrAddr;
            memWdata   = Data_Write[Data_Width*g +: Data_Width];
            case (state_q)
               Idle: begin
                  if (Mem_Clear[g]) begin
                     state_d    = Clearing;
                     clearCnt_d = '0;
                  end else if (En_Chip_Select[g]) begin
                     if (En_Write[g]) begin
                        memWe = 1'b1;
                     end
                     if (En_Read[g]) begin
                        rdData_d  = mem[rdAddr];
                        rdValid_d = 1'b1;
                     end
                  end
               end
               Clearing: begin
                  memWe      = 1'b1;
                  memAddr    = clearCnt_q;
                  memWdata   = '0;
                  clearCnt_d = clearCnt_q + Addr_Width'(1);
                  if (clearCnt_q == LastAddr) begin
                     state_d = Idle;
                  end
               end
               default: begin
                  state_d = Idle;
               end
            endcase
            if (Mem_reset) begin
               memWe = 1'b0;
            end
         end

         // State, clear counter and registered read port. Reset returns the
         // RAM to Idle and clears its outputs but not the array.
         always_ff @(posedge clk) begin
            if (Mem_reset) begin
               state_q    <= Idle;
               clearCnt_q <= '0;
               rdData_q   <= '0;
               rdValid_q  <= 1'b0;
            end else begin
               state_q    <= state_d;
               clearCnt_q <= clearCnt_d;
               rdData_q   <= rdData_d;
               rdValid_q  <= rdValid_d;
            end
         end

         // Storage array: single write port shared by normal writes and the
         // clear sequencer, no reset so it maps onto plain RAM.
         always_ff @(posedge clk) begin
            if (memWe) begin
               mem[memAddr] <= memWdata;
            end
         end

         assign Data_Read[Data_Width*g +: Data_Width] = rdData_q;
         assign Read_Valid[g] = rdValid_q;
         assign Clear_Busy[g] = (state_q == Clearing);
      end
   endgenerate

endmodule

// File: tb/tb_sram_bank.sv
// ---------------------------------------------------------------------------
// tb_sram_bank
// Self-checking bench for sram_bank. A behavioural model (word arrays plus a
// per-RAM "words left to clear" count) predicts every output each cycle;
// directed scenarios add explicit constant checks, followed by random traffic.
// ---------------------------------------------------------------------------
module tb_sram_bank;

   localparam int AW = 4;
   localparam int RD = 1 << AW;
   localparam int NS = 3;
   localparam int DW = 8;

   logic              clk;
   logic              Mem_reset;
   logic [NS-1:0]     clr, cs, we, rd;
   logic [NS*RD-1:0]  addrR, addrW;
   logic [NS*DW-1:0]  wdata;
   logic [NS*DW-1:0]  Data_Read;
   logic [NS-1:0]     Read_Valid;
   logic [NS-1:0]     Clear_Busy;

   int errorCount = 0;
   int checkCount = 0;

   logic [DW-1:0]     model [NS][RD];
   int                clearLeft [NS];
   logic [NS*DW-1:0]  expData  = '0;
   logic [NS-1:0]     expValid = '0;
   logic [NS-1:0]     expBusy  = '0;

   sram_bank #(
      .Addr_Width(AW),
      .Ram_Depth (RD),
      .Nums_SRAM (NS),
      .Data_Width(DW)
   ) dut (
      .clk           (clk),
      .Mem_reset     (Mem_reset),
      .Mem_Clear     (clr),
      .En_Chip_Select(cs),
      .En_Write      (we),
      .En_Read       (rd),
      .Addr_Read     (addrR),
      .Addr_Write    (addrW),
      .Data_Write    (wdata),
      .Data_Read     (Data_Read),
      .Read_Valid    (Read_Valid),
      .Clear_Busy    (Clear_Busy)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts the check and reports any difference
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drop every command strobe on all RAMs
   task automatic idleAll();
      clr = '0;
      cs  = '0;
      we  = '0;
      rd  = '0;
   endtask

   // Set one RAM's command slice; upper address bits get random junk
   task automatic applyStimulus(input int r, input bit c, input bit s, input bit w,
                                input bit rdE, input int ar, input int aw,
                                input logic [DW-1:0] d);
      clr[r] = c;
      cs[r]  = s;
      we[r]  = w;
      rd[r]  = rdE;
      addrR[RD*r +: RD] = {12'($urandom), 4'(ar)};
      addrW[RD*r +: RD] = {12'($urandom), 4'(aw)};
      wdata[DW*r +: DW] = d;
   endtask

   // Reference behaviour for one rising edge, from the currently driven inputs
   task automatic modelEdge();
      for (int r = 0; r < NS; r++) begin
         int ar, aw;
         logic [DW-1:0] oldWord;
         expValid[r] = 1'b0;
         if (Mem_reset) begin
            clearLeft[r] = 0;
            expData[DW*r +: DW] = '0;
         end else if (clearLeft[r] > 0) begin
            model[r][RD - clearLeft[r]] = '0;
            clearLeft[r]--;
         end else if (clr[r]) begin
            clearLeft[r] = RD;
         end else if (cs[r]) begin
            ar = int'(addrR[RD*r +: AW]);
            aw = int'(addrW[RD*r +: AW]);
            oldWord = model[r][ar];
            if (rd[r]) begin
               expData[DW*r +: DW] = oldWord;
               expValid[r] = 1'b1;
            end
            if (we[r]) begin
               model[r][aw] = wdata[DW*r +: DW];
            end
         end
         expBusy[r] = (clearLeft[r] > 0);
      end
   endtask

   // One clock: update the model at the edge, compare outputs 1 time unit later
   task automatic stepCycle();
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("data_read", 64'(Data_Read), 64'(expData));
      checkOutput("read_valid", 64'(Read_Valid), 64'(expValid));
      checkOutput("clear_busy", 64'(Clear_Busy), 64'(expBusy));
   endtask

   // Issue a single read on RAM r, address a
   task automatic readWord(input int r, input int a);
      idleAll();
      applyStimulus(r, 1'b0, 1'b1, 1'b0, 1'b1, a, 0, '0);
      stepCycle();
      idleAll();
   endtask

   // Let RAM r's clear run out, bounded so a stuck sequencer cannot hang
   task automatic waitClearDone(input int r);
      int n;
      n = 0;
      while (Clear_Busy[r] && n < 40) begin
         n++;
         stepCycle();
      end
      checkOutput("clear_done", 64'(Clear_Busy[r]), 64'(0));
   endtask

   initial begin
      int busyCycles;
      for (int r = 0; r < NS; r++) begin
         clearLeft[r] = 0;
         for (int a = 0; a < RD; a++) model[r][a] = '0;
      end
      idleAll();
      addrR = '0;
      addrW = '0;
      wdata = '0;

      // Reset held two cycles, outputs must all be zero
      Mem_reset = 1'b1;
      repeat (2) stepCycle();
      checkOutput("rst_data", 64'(Data_Read), 64'(0));
      checkOutput("rst_valid", 64'(Read_Valid), 64'(0));
      checkOutput("rst_busy", 64'(Clear_Busy), 64'(0));
      Mem_reset = 1'b0;

      // Write RAM1 addr 5 then read it back next cycle
      applyStimulus(1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 5, 8'hA5);
      stepCycle();
      readWord(1, 5);
      checkOutput("rd_a5_data", 64'(Data_Read[15:8]), 64'hA5);
      checkOutput("rd_a5_valid", 64'(Read_Valid), 64'b010);
      stepCycle();
      checkOutput("rd_a5_pulse", 64'(Read_Valid), 64'b000);

      // Fill RAM0 with addr+1 and RAM2 with 0x30+addr
      $display("[TB] clear sequence on RAM0");
      for (int a = 0; a < RD; a++) begin
         idleAll();
         applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, 0, a, 8'(a + 1));
         applyStimulus(2, 1'b0, 1'b1, 1'b1, 1'b0, 0, a, 8'(8'h30 + a));
         stepCycle();
      end
      idleAll();
      applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, '0);
      stepCycle();
      idleAll();
      busyCycles = 0;
      while (Clear_Busy[0] && busyCycles < 40) begin
         busyCycles++;
         if (busyCycles == 5) begin
            applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b1, 3, 15, 8'h77);
         end
         stepCycle();
         if (busyCycles == 5) begin
            checkOutput("clr_rd_ignored", 64'(Read_Valid[0]), 64'(0));
         end
         idleAll();
      end
      checkOutput("clr_busy_len", 64'(busyCycles), 64'(16));
      for (int a = 0; a < RD; a++) begin
         readWord(0, a);
         checkOutput("clr_zero", 64'(Data_Read[7:0]), 64'(0));
         checkOutput("clr_zero_valid", 64'(Read_Valid[0]), 64'(1));
         readWord(2, a);
         checkOutput("ram2_intact", 64'(Data_Read[23:16]), 64'(8'(8'h30 + a)));
      end

      // Read-during-write on RAM1 addr 7 returns the old word
      applyStimulus(1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 7, 8'h11);
      stepCycle();
      idleAll();
      applyStimulus(1, 1'b0, 1'b1, 1'b1, 1'b1, 7, 7, 8'h22);
      stepCycle();
      idleAll();
      checkOutput("rdw_old", 64'(Data_Read[15:8]), 64'h11);
      readWord(1, 7);
      checkOutput("rdw_new", 64'(Data_Read[15:8]), 64'h22);

      // Write without chip select is ignored
      applyStimulus(1, 1'b0, 1'b0, 1'b1, 1'b1, 7, 7, 8'h55);
      stepCycle();
      idleAll();
      checkOutput("nocs_valid", 64'(Read_Valid[1]), 64'(0));
      readWord(1, 7);
      checkOutput("nocs_data", 64'(Data_Read[15:8]), 64'h22);

      // Clear beats a same-edge write
      applyStimulus(1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 2, 8'h99);
      stepCycle();
      idleAll();
      waitClearDone(1);
      readWord(1, 2);
      checkOutput("clr_prio", 64'(Data_Read[15:8]), 64'(0));

      // Reset four cycles into a RAM2 clear of 0xFF data
      $display("[TB] reset during RAM2 clear");
      for (int a = 0; a < RD; a++) begin
         idleAll();
         applyStimulus(2, 1'b0, 1'b1, 1'b1, 1'b0, 0, a, 8'hFF);
         stepCycle();
      end
      idleAll();
      applyStimulus(2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, '0);
      stepCycle();
      idleAll();
      repeat (4) stepCycle();
      Mem_reset = 1'b1;
      stepCycle();
      checkOutput("rst_abort_busy", 64'(Clear_Busy), 64'(0));
      Mem_reset = 1'b0;
      for (int a = 0; a < RD; a++) begin
         readWord(2, a);
         checkOutput("rst_abort_word", 64'(Data_Read[23:16]), (a < 4) ? 64'h00 : 64'hFF);
      end

      // Random traffic on all RAMs against the model
      $display("[TB] random traffic");
      for (int n = 0; n < 600; n++) begin
         Mem_reset = ($urandom_range(0, 249) == 0);
         for (int r = 0; r < NS; r++) begin
            applyStimulus(r, ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                          1'($urandom), 1'($urandom), int'($urandom_range(0, RD - 1)),
                          int'($urandom_range(0, RD - 1)), 8'($urandom));
         end
         stepCycle();
      end
      Mem_reset = 1'b0;
      idleAll();
      stepCycle();

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
